// File: rtl/ram_wr_arbiter_if.sv
// Store-request and RAM write-port bundle for ram_wr_arbiter.
// master = issue slots + RAM side (drives requests, samples strobe/flags); slave = arbiter.
interface ram_wr_arbiter_if #(
  parameter int ADDR_WIDTH       = 11,
  parameter int DOUBLEWORD_WIDTH = 64,
  parameter int DATA_TYPE_WIDTH  = 2
);
  logic                        req0_valid;
  logic                        req0_ready;
  logic [ADDR_WIDTH-1:0]       req0_addr;
  logic [DOUBLEWORD_WIDTH-1:0] req0_data;
  logic [DATA_TYPE_WIDTH-1:0]  req0_type;
  logic                        req1_valid;
  logic                        req1_ready;
  logic [ADDR_WIDTH-1:0]       req1_addr;
  logic [DOUBLEWORD_WIDTH-1:0] req1_data;
  logic [DATA_TYPE_WIDTH-1:0]  req1_type;
  logic                        mem_wr_ins;
  logic [ADDR_WIDTH-1:0]       mem_addr_wr;
  logic [DOUBLEWORD_WIDTH-1:0] mem_data_bus_wr;
  logic [DATA_TYPE_WIDTH-1:0]  mem_data_type_wr;
  logic                        mem_wr_idle;
  logic                        err_misalign;
  logic                        err_src;
  logic                        err_timeout;
  logic                        busy;

  modport slave (
    input  req0_valid, req0_addr, req0_data, req0_type,
    input  req1_valid, req1_addr, req1_data, req1_type,
    input  mem_wr_idle,
    output req0_ready, req1_ready,
    output mem_wr_ins, mem_addr_wr, mem_data_bus_wr, mem_data_type_wr,
    output err_misalign, err_src, err_timeout, busy
  );

  modport master (
    output req0_valid, req0_addr, req0_data, req0_type,
    output req1_valid, req1_addr, req1_data, req1_type,
    output mem_wr_idle,
    input  req0_ready, req1_ready,
    input  mem_wr_ins, mem_addr_wr, mem_data_bus_wr, mem_data_type_wr,
    input  err_misalign, err_src, err_timeout, busy
  );
endinterface

// File: rtl/ram_wr_arbiter.sv
// Round-robin write-port arbiter for the dual-issue core: accepts one store, screens
// type/alignment, strobes the RAM once and waits for write-idle (with a hang timeout).
module ram_wr_arbiter #(
  parameter int ADDR_WIDTH       = 11,
  parameter int DOUBLEWORD_WIDTH = 64,
  parameter int DATA_TYPE_WIDTH  = 2,
  parameter int MIN_WAIT         = 2,
  parameter int WAIT_TIMEOUT     = 15
) (
  input  logic            clk,
  input  logic            rst,
  ram_wr_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_TOUT = CNT_W'(WAIT_TIMEOUT - 1);
  localparam logic [DATA_TYPE_WIDTH-1:0] T_WORD = DATA_TYPE_WIDTH'(1);
  localparam logic [DATA_TYPE_WIDTH-1:0] T_DW   = DATA_TYPE_WIDTH'(2);
  localparam logic [DATA_TYPE_WIDTH-1:0] T_BAD  = DATA_TYPE_WIDTH'(3);

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, WAIT} state_e;

  state_e                      state_q, state_d;
  logic                        last_grant_q, last_grant_d;
  logic                        src_q, src_d;
  logic [CNT_W-1:0]            wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [DOUBLEWORD_WIDTH-1:0] data_q, data_d;
  logic [DATA_TYPE_WIDTH-1:0]  type_q, type_d;
  logic                        err_src_q, err_src_d;
  logic                        err_timeout_q, err_timeout_d;
  logic                        busy_q;

  logic [1:0] valid;
  logic       winner, arb_open, accept, illegal;

  assign valid = {bus.req1_valid, bus.req0_valid};

  // Prefer the slot that did not win last time; fall back to the previous winner.
  always_comb begin
    winner = last_grant_q;
    if (valid[~last_grant_q]) winner = ~last_grant_q;
  end

  assign arb_open = (state_q == IDLE) && bus.mem_wr_idle && !rst;
  assign accept   = arb_open && valid[winner];

  assign bus.req0_ready = accept && (winner == 1'b0);
  assign bus.req1_ready = accept && (winner == 1'b1);

  assign illegal = (type_q == T_BAD) ||
                   ((type_q == T_DW)   && (addr_q[2:0] != 3'd0)) ||
                   ((type_q == T_WORD) && (addr_q[1:0] != 2'd0));

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    src_d         = src_q;
    wait_cnt_d    = wait_cnt_q;
    addr_d        = addr_q;
    data_d        = data_q;
    type_d        = type_q;
    err_src_d     = err_src_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d       = winner ? bus.req1_addr : bus.req0_addr;
          data_d       = winner ? bus.req1_data : bus.req0_data;
          type_d       = winner ? bus.req1_type : bus.req0_type;
          src_d        = winner;
          last_grant_d = winner;
          state_d      = CHECK;
        end
      end
      CHECK: begin
        if (illegal) begin
          err_src_d = src_q;
          state_d   = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // Normal exit takes priority over the timeout on the same cycle.
        if (wait_cnt_q >= CNT_MIN && bus.mem_wr_idle) begin
          state_d = IDLE;
        end else if (wait_cnt_q >= CNT_TOUT) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      src_q         <= 1'b0;
      wait_cnt_q    <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      type_q        <= '0;
      err_src_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      src_q         <= src_d;
      wait_cnt_q    <= wait_cnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      type_q        <= type_d;
      err_src_q     <= err_src_d;
      err_timeout_q <= err_timeout_d;
      busy_q        <= (state_d != IDLE);
    end
  end

  assign bus.mem_wr_ins       = (state_q == ISSUE);
  assign bus.mem_addr_wr      = addr_q;
  assign bus.mem_data_bus_wr  = data_q;
  assign bus.mem_data_type_wr = type_q;
  assign bus.err_misalign     = (state_q == CHECK) && illegal;
  assign bus.err_src          = err_src_q;
  assign bus.err_timeout      = err_timeout_q;
  assign bus.busy             = busy_q;
endmodule
